// File: rtl/fifo_rf_ctrl.sv
// Pointer and flag controller that turns a register file into a FIFO.
// Each push writes two entries and each pop reads one entry.
module fifo_rf_ctrl #(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr,
  input  logic                  rd,
  output logic                  w_en,
  output logic [ADDR_WIDTH-1:0] w_addr0,
  output logic [ADDR_WIDTH-1:0] w_addr1,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic                  empty,
  output logic                  full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  ovf_err,
  output logic                  unf_err
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_LIM =
    (ADDR_WIDTH + 1)'(DEPTH - 2);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  push;
  logic                  pop;
  logic [ADDR_WIDTH:0]   add_n;
  logic [ADDR_WIDTH:0]   sub_n;

  // Full means fewer than two free entries, since a push needs two.
  assign empty   = (count == '0);
  assign full    = (count > FULL_LIM);
  assign push    = wr & ~full;
  assign pop     = rd & ~empty;
  assign w_en    = push;
  assign w_addr0 = wr_ptr;
  assign w_addr1 = wr_ptr + ADDR_WIDTH'(1);
  assign r_addr  = rd_ptr;
  assign add_n   = (ADDR_WIDTH + 1)'({push, 1'b0});
  assign sub_n   = (ADDR_WIDTH + 1)'(pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ovf_err <= 1'b0;
      unf_err <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + ADDR_WIDTH'(2);
      if (pop)
        rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      count   <= count + add_n - sub_n;
      ovf_err <= ovf_err | (wr & full);
      unf_err <= unf_err | (rd & empty);
    end
  end

endmodule
